piso_ctrl: RTL and testbench

Serializer controller that sequences a WIDTH-bit parallel-in/serial-out shift register between a valid/ready word source and a serial sink. Accepts one parallel word per handshake, emits it LSB-first one bit per clock with frame markers, and inserts a programmable idle gap between frames. It also drives the shift/load select (`sl`) of the standalone PISO datapath, so an external `piso` instance can be run in lock-step with it.

---
 rtl/piso_ctrl.sv | 152 +++++++++++++++
 tb/tb_piso_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/piso_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : piso_ctrl
//  Description : Serializer controller. Accepts a WIDTH-bit word on a
//                valid/ready handshake, sends it LSB-first one bit per clock
//                with frame_start/frame_end markers, then holds the line idle
//                for GAP cycles. Also drives the load/shift select (sl) of an
//                external PISO datapath so both stay in lock-step.
//                Optional feature macro: PISO_CTRL_PARITY_EN appends an even
//                parity bit to every frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_ctrl #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy,
    output logic             sl
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [7:0]      GAP_LAST = 8'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic            NO_GAP   = (GAP == 0);

`ifdef PISO_CTRL_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_PAR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;
`endif

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [7:0]       gap_cnt;
    logic             last_bit;
    logic             final_cyc;
    logic             gap_last;
    logic             hs;
`ifdef PISO_CTRL_PARITY_EN
    logic             parity;
`endif

    // Frame/gap terminal conditions and the handshake decode.
    always_comb begin
        last_bit  = (state == ST_SHIFT) && (cnt == CNT_LAST);
`ifdef PISO_CTRL_PARITY_EN
        final_cyc = (state == ST_PAR);
`else
        final_cyc = last_bit;
`endif
        gap_last  = (state == ST_GAP) && (gap_cnt == GAP_LAST);
        // Ready depends only on state and counters so sources may wait on it.
        in_ready  = (state == ST_IDLE) || (final_cyc && NO_GAP) || gap_last;
        hs        = in_valid && in_ready;
        sl        = ~hs;
    end

    // Next-state logic and serial-side outputs.
    always_comb begin
        state_nx    = state;
        ser_out     = 1'b0;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        frame_end   = final_cyc;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (hs) state_nx = ST_SHIFT;
            end
            ST_SHIFT: begin
                ser_out     = shreg[0];
                ser_valid   = 1'b1;
                frame_start = (cnt == '0);
                if (last_bit) begin
`ifdef PISO_CTRL_PARITY_EN
                    state_nx = ST_PAR;
`else
                    if (!NO_GAP) state_nx = ST_GAP;
                    else         state_nx = hs ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
`ifdef PISO_CTRL_PARITY_EN
            ST_PAR: begin
                ser_out   = parity;
                ser_valid = 1'b1;
                if (!NO_GAP) state_nx = ST_GAP;
                else         state_nx = hs ? ST_SHIFT : ST_IDLE;
            end
`endif
            ST_GAP: begin
                if (gap_last) state_nx = hs ? ST_SHIFT : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Shift register, bit counter and parity capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
`ifdef PISO_CTRL_PARITY_EN
            parity <= 1'b0;
`endif
        end else if (hs) begin
            shreg <= in_data;
            cnt   <= '0;
`ifdef PISO_CTRL_PARITY_EN
            parity <= ^in_data;
`endif
        end else if (state == ST_SHIFT) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
    end

    // Gap counter runs only inside the gap and restarts from zero each time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           gap_cnt <= '0;
        else if (state == ST_GAP && !gap_last) gap_cnt <= gap_cnt + 1'b1;
        else                                  gap_cnt <= '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_ctrl
//  Description : Directed self-checking bench for piso_ctrl (WIDTH=4) with
//                one instance at GAP=1 and one at GAP=0. Honors
//                PISO_CTRL_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_ctrl;

`ifdef PISO_CTRL_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v1 = 1'b0, v0 = 1'b0;
    logic [3:0] d1 = '0, d0 = '0;
    logic       rdy1, so1, sv1, fs1, fe1, bz1, sl1;
    logic       rdy0, so0, sv0, fs0, fe0, bz0, sl0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    piso_ctrl #(.WIDTH(4), .GAP(1)) u_gap1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .ser_out(so1), .ser_valid(sv1), .frame_start(fs1), .frame_end(fe1),
        .busy(bz1), .sl(sl1)
    );

    piso_ctrl #(.WIDTH(4), .GAP(0)) u_gap0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
        .ser_out(so0), .ser_valid(sv0), .frame_start(fs0), .frame_end(fe0),
        .busy(bz0), .sl(sl0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check one whole frame on instance sel (1: GAP=1, 0: GAP=0). Word bits are
    // sent LSB first, followed by par when parity is built in.
    task automatic run_frame(input int sel, input logic [3:0] w, input logic par,
                             input logic rdy_end, input logic sl_end);
        logic [4:0] bits;
        bits = {par, w};
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            chk("ser_valid", sel ? sv1 : sv0, 1);
            chk("ser_out",   sel ? so1 : so0, bits[i]);
            chk("frame_start", sel ? fs1 : fs0, (i == 0));
            chk("frame_end",   sel ? fe1 : fe0, (i == FL - 1));
            if (i == FL - 1) begin
                chk("ready_at_end", sel ? rdy1 : rdy0, rdy_end);
                chk("sl_at_end",    sel ? sl1 : sl0, sl_end);
            end
            step();
        end
    endtask

    initial begin
        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ser_out", so1, 0);
        chk("rst_ser_valid", sv1, 0);
        chk("rst_fs", fs1, 0);
        chk("rst_fe", fe1, 0);
        chk("rst_busy", bz1, 0);
        chk("rst_ready", rdy1, 1);
        chk("rst_sl", sl1, 1);
        chk("rst_ready0", rdy0, 1);
        step();
        rst_n = 1'b1;

        // Idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_sv", sv1, 0);
            chk("idle_busy", bz1, 0);
            chk("idle_sl", sl1, 1);
            step();
        end

        // Single-cycle pulse, word 1011, accepted immediately
        v1 = 1'b1; d1 = 4'b1011;
        @(negedge clk);
        chk("pulse_ready", rdy1, 1);
        chk("pulse_sl", sl1, 0);
        step();
        v1 = 1'b0; d1 = 4'b0000;
        run_frame(1, 4'b1011, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("gap_sv", sv1, 0);
        chk("gap_ready", rdy1, 1);
        chk("gap_busy", bz1, 1);
        step();
        @(negedge clk);
        chk("after_gap_busy", bz1, 0);
        step();

        // Continuous valid at GAP=1: A then 5, data changes mid-frame
        v1 = 1'b1; d1 = 4'hA;
        @(negedge clk);
        chk("a_sl", sl1, 0);
        step();
        d1 = 4'h5;
        run_frame(1, 4'hA, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("ab_gap_sv", sv1, 0);
        chk("ab_gap_ready", rdy1, 1);
        chk("ab_gap_sl", sl1, 0);
        step();
        v1 = 1'b0;
        run_frame(1, 4'h5, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("b_gap_sv", sv1, 0);
        step();
        @(negedge clk);
        chk("b_idle_busy", bz1, 0);
        step();

        // GAP=0: three back-to-back words, contiguous
        v0 = 1'b1; d0 = 4'b0111;
        @(negedge clk);
        chk("c0_sl", sl0, 0);
        step();
        d0 = 4'b0000;
        run_frame(0, 4'b0111, 1'b1, 1'b1, 1'b0);
        d0 = 4'b1100;
        run_frame(0, 4'b0000, 1'b0, 1'b1, 1'b0);
        v0 = 1'b0; d0 = 4'b1111;
        run_frame(0, 4'b1100, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("c_end_sv", sv0, 0);
        chk("c_end_busy", bz0, 0);
        step();

        // Asynchronous reset during bit 2
        v1 = 1'b1; d1 = 4'b1011;
        step();
        v1 = 1'b0;
        @(negedge clk); chk("mid_b0", so1, 1); step();
        @(negedge clk); chk("mid_b1", so1, 1); step();
        @(negedge clk); chk("mid_b2_sv", sv1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sv", sv1, 0);
        chk("arst_busy", bz1, 0);
        chk("arst_so", so1, 0);
        chk("arst_ready", rdy1, 1);
        chk("arst_sl", sl1, 1);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_sv", sv1, 0);
            chk("post_rst_busy", bz1, 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
